ray_march_core: RTL and testbench

// - Parametrised successor to ray_unit: sphere-traces one ray per pixel, accumulating distance t

---
 rtl/ray_march_core_pkg.sv | 56 +++++
 rtl/ray_march_core_point_eval.sv | 26 ++
 rtl/ray_march_core.sv | 137 +++++++++++++
 tb/tb_ray_march_core.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_march_core_pkg.sv
// Shared vector/fixed-point package for the ray marcher.
// Owns the fp format (signed Q16.16), vec3, the arithmetic helpers and the march FSM states.
package ray_march_core_pkg;

  localparam int unsigned FP_BITS = 32;
  localparam int unsigned FP_FRAC = 16;

  typedef logic signed [FP_BITS-1:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  localparam fp FP_MAX = {1'b0, {(FP_BITS-1){1'b1}}};
  localparam fp FP_MIN = {1'b1, {(FP_BITS-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, REQ, WAIT, UPDATE, DONE} ray_state_t;

  // Only meant for constant elaboration (parameter defaults, bench constants).
  function automatic fp fp_from_real(input real r);
    return fp'($rtoi(r * (2.0 ** FP_FRAC)));
  endfunction

  function automatic vec3 make_vec3(input fp x, input fp y, input fp z);
    vec3 v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

  function automatic fp fp_mul(input fp a, input fp b);
    logic signed [2*FP_BITS-1:0] aw;
    logic signed [2*FP_BITS-1:0] bw;
    logic signed [2*FP_BITS-1:0] p;
    aw = (2*FP_BITS)'(a);
    bw = (2*FP_BITS)'(b);
    p  = aw * bw;
    return fp'(p >>> FP_FRAC);
  endfunction

  function automatic fp fp_sat_add(input fp a, input fp b);
    logic signed [FP_BITS:0] s;
    s = (FP_BITS+1)'(a) + (FP_BITS+1)'(b);
    // Overflow when the extra sign bit disagrees with the fp sign bit.
    if (s[FP_BITS] != s[FP_BITS-1]) return s[FP_BITS] ? FP_MIN : FP_MAX;
    return fp'(s[FP_BITS-1:0]);
  endfunction

  function automatic vec3 vec3_add(input vec3 a, input vec3 b);
    return make_vec3(a.x + b.x, a.y + b.y, a.z + b.z);
  endfunction

endpackage

// File: rtl/ray_march_core_point_eval.sv
// ray_point_eval: registered sample point pos = origin + t*dir.
// Ports: clk_in/rst_in (sync active-high), en_in loads a new point,
//        origin_in/dir_in/t_in operands, pos_out registered result.
module ray_point_eval
  import ray_march_core_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  input  vec3  origin_in,
  input  vec3  dir_in,
  input  fp    t_in,
  output vec3  pos_out
);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pos_out <= '0;
    end else if (en_in) begin
      pos_out <= vec3_add(origin_in, make_vec3(fp_mul(t_in, dir_in.x),
                                               fp_mul(t_in, dir_in.y),
                                               fp_mul(t_in, dir_in.z)));
    end
  end

endmodule

// File: rtl/ray_march_core.sv
// ray_march_core: sphere-traces one ray per pixel against an external SDF evaluator.
// Ports: clk_in/rst_in (sync active-high); ray input handshake valid_in/ready_out with
//        origin, direction, fractal select and pixel coords; SDF request handshake
//        sdf_valid_out/sdf_ready_in carrying sdf_pos_out/sdf_sel_out; SDF response pulse
//        sdf_valid_in/sdf_dist_in; result handshake valid_out/out_ready_in with
//        hcount_out/vcount_out/color_out/hit_out.
module ray_march_core
  import ray_march_core_pkg::*;
#(
  parameter int unsigned H_BITS     = 9,
  parameter int unsigned V_BITS     = 9,
  parameter int unsigned SEL_BITS   = 3,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned MAX_STEPS  = 64,
  parameter int unsigned STEP_SHIFT = 2,
  parameter fp           EPSILON    = fp_from_real(0.01),
  parameter fp           MAX_DIST   = fp_from_real(8.0)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  vec3                   ray_origin_in,
  input  vec3                   ray_direction_in,
  input  logic [SEL_BITS-1:0]   fractal_sel_in,
  input  logic [H_BITS-1:0]     hcount_in,
  input  logic [V_BITS-1:0]     vcount_in,
  output logic                  sdf_valid_out,
  input  logic                  sdf_ready_in,
  output vec3                   sdf_pos_out,
  output logic [SEL_BITS-1:0]   sdf_sel_out,
  input  logic                  sdf_valid_in,
  input  fp                     sdf_dist_in,
  output logic                  valid_out,
  input  logic                  out_ready_in,
  output logic [H_BITS-1:0]     hcount_out,
  output logic [V_BITS-1:0]     vcount_out,
  output logic [COLOR_BITS-1:0] color_out,
  output logic                  hit_out
);

  localparam int unsigned STEP_W    = $clog2(MAX_STEPS + 1);
  localparam int unsigned COLOR_MAX = (1 << COLOR_BITS) - 1;

  ray_state_t          state_q, state_d;
  vec3                 origin_q, dir_q;
  fp                   t_q, dist_q;
  logic [STEP_W-1:0]   steps_q;

  logic [STEP_W-1:0]   steps_inc;
  fp                   t_sum;
  logic                hit_now, escape;
  int unsigned         shade;
  logic [COLOR_BITS-1:0] color_next;

  ray_point_eval u_point_eval (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_in     (state_q == ISSUE),
    .origin_in (origin_q),
    .dir_in    (dir_q),
    .t_in      (t_q),
    .pos_out   (sdf_pos_out)
  );

  assign ready_out     = (state_q == IDLE);
  assign sdf_valid_out = (state_q == REQ);
  assign valid_out     = (state_q == DONE);

  // March-step decision, only consumed in UPDATE.
  always_comb begin
    steps_inc = steps_q + STEP_W'(1);
    t_sum     = fp_sat_add(t_q, dist_q);
    hit_now   = (dist_q < EPSILON);
    escape    = (t_sum > MAX_DIST) || (steps_inc == STEP_W'(MAX_STEPS));
    shade     = 32'(steps_inc) >> STEP_SHIFT;
    if (shade > COLOR_MAX) shade = COLOR_MAX;
    color_next = hit_now ? COLOR_BITS'(COLOR_MAX - shade) : '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_in) state_d = ISSUE;
      ISSUE:   state_d = REQ;
      REQ:     if (sdf_ready_in) state_d = WAIT;
      WAIT:    if (sdf_valid_in) state_d = UPDATE;
      UPDATE:  state_d = (hit_now || escape) ? DONE : ISSUE;
      DONE:    if (out_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      origin_q    <= '0;
      dir_q       <= '0;
      t_q         <= '0;
      dist_q      <= '0;
      steps_q     <= '0;
      sdf_sel_out <= '0;
      hcount_out  <= '0;
      vcount_out  <= '0;
      hit_out     <= 1'b0;
      color_out   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            origin_q    <= ray_origin_in;
            dir_q       <= ray_direction_in;
            sdf_sel_out <= fractal_sel_in;
            hcount_out  <= hcount_in;
            vcount_out  <= vcount_in;
            t_q         <= '0;
            steps_q     <= '0;
          end
        end
        WAIT: begin
          if (sdf_valid_in) dist_q <= sdf_dist_in;
        end
        UPDATE: begin
          steps_q <= steps_inc;
          t_q     <= t_sum;
          if (hit_now || escape) begin
            hit_out   <= hit_now;
            color_out <= color_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_march_core.sv
// Directed bench for ray_march_core with a zero-wait unit-sphere SDF stub.
module tb_ray_march_core;
  import ray_march_core_pkg::*;

  localparam fp ONE = fp_from_real(1.0);

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       valid_in = 1'b0;
  logic       ready_out;
  vec3        ray_origin_in = '0;
  vec3        ray_direction_in = '0;
  logic [2:0] fractal_sel_in = '0;
  logic [8:0] hcount_in = '0;
  logic [8:0] vcount_in = '0;
  logic       sdf_valid_out;
  logic       sdf_ready_in = 1'b1;
  vec3        sdf_pos_out;
  logic [2:0] sdf_sel_out;
  logic       sdf_valid_in;
  fp          sdf_dist_in;
  logic       valid_out;
  logic       out_ready_in = 1'b1;
  logic [8:0] hcount_out;
  logic [8:0] vcount_out;
  logic [3:0] color_out;
  logic       hit_out;

  // Stub state
  logic stub_en = 1'b1;
  int   stub_mode = 0;   // 0: unit sphere, 1: constant 0.02
  logic resp_v = 1'b0;
  fp    resp_d = '0;
  logic inj_v = 1'b0;
  fp    inj_d = '0;
  int   req_cnt = 0;

  int n_vec = 0;
  int n_err = 0;

  assign sdf_valid_in = resp_v | inj_v;
  assign sdf_dist_in  = inj_v ? inj_d : resp_d;

  always #5 clk = ~clk;

  ray_march_core dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .ray_origin_in    (ray_origin_in),
    .ray_direction_in (ray_direction_in),
    .fractal_sel_in   (fractal_sel_in),
    .hcount_in        (hcount_in),
    .vcount_in        (vcount_in),
    .sdf_valid_out    (sdf_valid_out),
    .sdf_ready_in     (sdf_ready_in),
    .sdf_pos_out      (sdf_pos_out),
    .sdf_sel_out      (sdf_sel_out),
    .sdf_valid_in     (sdf_valid_in),
    .sdf_dist_in      (sdf_dist_in),
    .valid_out        (valid_out),
    .out_ready_in     (out_ready_in),
    .hcount_out       (hcount_out),
    .vcount_out       (vcount_out),
    .color_out        (color_out),
    .hit_out          (hit_out)
  );

  function automatic fp sdf_fn(input vec3 p);
    real x, y, z;
    if (stub_mode == 1) return fp_from_real(0.02);
    x = $itor(p.x) / 65536.0;
    y = $itor(p.y) / 65536.0;
    z = $itor(p.z) / 65536.0;
    return fp_from_real($sqrt(x * x + y * y + z * z) - 1.0);
  endfunction

  // Response arrives the cycle after the request handshake, i.e. during WAIT.
  always @(posedge clk) begin
    resp_v <= stub_en && sdf_valid_out && sdf_ready_in;
    resp_d <= sdf_fn(sdf_pos_out);
    if (sdf_valid_out && sdf_ready_in) req_cnt <= req_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_ray(input vec3 o, input vec3 d, input logic [2:0] sel,
                          input logic [8:0] h, input logic [8:0] v);
    int n;
    ray_origin_in    = o;
    ray_direction_in = d;
    fractal_sel_in   = sel;
    hcount_in        = h;
    vcount_in        = v;
    valid_in         = 1'b1;
    n = 0;
    while (!ready_out && n < 100) begin
      step();
      n++;
    end
    check("accept_ready", 96'(ready_out), 96'(1));
    step();
    valid_in = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!valid_out && cyc < 2000) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    int  base;
    logic bad;
    vec3 pos_snap;
    vec3 dir_z;
    dir_z = make_vec3('0, '0, ONE);

    // Reset state
    step();
    step();
    rst_in = 1'b0;
    check("rst_ready", 96'(ready_out), 96'(1));
    check("rst_sdf_valid", 96'(sdf_valid_out), 96'(0));
    check("rst_valid", 96'(valid_out), 96'(0));
    check("rst_hit_color", 96'({hit_out, color_out}), 96'(0));
    check("rst_hv", 96'({hcount_out, vcount_out}), 96'(0));
    check("rst_pos", 96'(sdf_pos_out), 96'(0));
    check("rst_sel", 96'(sdf_sel_out), 96'(0));

    // 1: hit after two steps, 8-cycle latency
    base = req_cnt;
    send_ray(make_vec3('0, '0, -2 * ONE), dir_z, 3'd1, 9'd150, 9'd150);
    wait_done(cyc);
    check("t1_latency", 96'(cyc), 96'(8));
    check("t1_valid", 96'(valid_out), 96'(1));
    check("t1_ready_low", 96'(ready_out), 96'(0));
    check("t1_hit", 96'(hit_out), 96'(1));
    check("t1_color", 96'(color_out), 96'(15));
    check("t1_hv", 96'({hcount_out, vcount_out}), 96'({9'd150, 9'd150}));
    check("t1_reqs", 96'(req_cnt - base), 96'(2));
    step();

    // 2: escape past MAX_DIST after 4 steps
    base = req_cnt;
    send_ray(make_vec3('0, 3 * ONE, -2 * ONE), dir_z, 3'd2, 9'd3, 9'd4);
    wait_done(cyc);
    check("t2_valid", 96'(valid_out), 96'(1));
    check("t2_hit", 96'(hit_out), 96'(0));
    check("t2_color", 96'(color_out), 96'(0));
    check("t2_reqs", 96'(req_cnt - base), 96'(4));
    step();

    // 3: step limit
    stub_mode = 1;
    base = req_cnt;
    send_ray(make_vec3('0, '0, -2 * ONE), dir_z, 3'd0, 9'd5, 9'd6);
    wait_done(cyc);
    check("t3_latency", 96'(cyc), 96'(256));
    check("t3_hit", 96'(hit_out), 96'(0));
    check("t3_color", 96'(color_out), 96'(0));
    check("t3_reqs", 96'(req_cnt - base), 96'(64));
    stub_mode = 0;
    step();

    // 4: output backpressure
    out_ready_in = 1'b0;
    send_ray(make_vec3('0, '0, -2 * ONE), dir_z, 3'd1, 9'd150, 9'd149);
    wait_done(cyc);
    bad = 1'b0;
    ray_origin_in = make_vec3('0, 3 * ONE, -2 * ONE);
    hcount_in = 9'd7;
    vcount_in = 9'd8;
    valid_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (valid_out !== 1'b1 || ready_out !== 1'b0 || hit_out !== 1'b1 ||
          color_out !== 4'd15 || hcount_out !== 9'd150 || vcount_out !== 9'd149) bad = 1'b1;
      step();
    end
    check("t4_stable", 96'(bad), 96'(0));
    valid_in = 1'b0;
    out_ready_in = 1'b1;
    step();
    check("t4_release_ready", 96'(ready_out), 96'(1));
    check("t4_release_valid", 96'(valid_out), 96'(0));
    send_ray(make_vec3('0, '0, -2 * ONE), dir_z, 3'd1, 9'd10, 9'd20);
    wait_done(cyc);
    check("t4_next_latency", 96'(cyc), 96'(8));
    check("t4_next_hv", 96'({hcount_out, vcount_out}), 96'({9'd10, 9'd20}));
    step();

    // 5: request stall, stale response in REQ, select forwarding
    sdf_ready_in = 1'b0;
    base = req_cnt;
    send_ray(make_vec3('0, 3 * ONE, -2 * ONE), dir_z, 3'd5, 9'd1, 9'd2);
    cyc = 0;
    while (!sdf_valid_out && cyc < 100) begin
      step();
      cyc++;
    end
    check("t5_req", 96'(sdf_valid_out), 96'(1));
    check("t5_sel", 96'(sdf_sel_out), 96'(5));
    check("t5_pos", 96'(sdf_pos_out), 96'(make_vec3('0, 3 * ONE, -2 * ONE)));
    pos_snap = sdf_pos_out;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inj_v = (i == 2);
      inj_d = '0;
      step();
      if (sdf_valid_out !== 1'b1 || sdf_pos_out !== pos_snap || sdf_sel_out !== 3'd5) bad = 1'b1;
    end
    inj_v = 1'b0;
    check("t5_stable", 96'(bad), 96'(0));
    sdf_ready_in = 1'b1;
    wait_done(cyc);
    check("t5_hit", 96'(hit_out), 96'(0));
    check("t5_reqs", 96'(req_cnt - base), 96'(4));
    step();

    // 6: reset in WAIT, then stale response
    stub_en = 1'b0;
    send_ray(make_vec3('0, '0, -2 * ONE), dir_z, 3'd6, 9'd77, 9'd88);
    cyc = 0;
    while (!sdf_valid_out && cyc < 100) begin
      step();
      cyc++;
    end
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    inj_v = 1'b1;
    inj_d = '0;
    step();
    inj_v = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (valid_out !== 1'b0 || ready_out !== 1'b1 || sdf_valid_out !== 1'b0) bad = 1'b1;
      step();
    end
    check("t6_idle", 96'(bad), 96'(0));
    check("t6_rst_outs", 96'({hit_out, color_out, hcount_out, vcount_out, sdf_sel_out}), 96'(0));
    check("t6_rst_pos", 96'(sdf_pos_out), 96'(0));
    stub_en = 1'b1;
    send_ray(make_vec3('0, '0, -2 * ONE), dir_z, 3'd1, 9'd150, 9'd150);
    wait_done(cyc);
    check("t6_after_latency", 96'(cyc), 96'(8));
    check("t6_after_hit_color", 96'({hit_out, color_out}), 96'({1'b1, 4'd15}));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
